mr16_host_mailbox: RTL
======================

Name: mr16_host_mailbox

Overview:
- Host-side (X1 Z80 I/O bus) counterpart of the mr16 sub-CPU GPIO/interrupt interface.
- Host→MCU: byte FIFO. The head byte is presented on the mr16 input port P0. The mr16 pops it by reading the IN-ack port (strobe I4). The block raises mr16 interrupt INT0 and clears it on ACK0.
- MCU→host: the mr16 writes output port P5 with a toggle flag. The block captures the byte into a receive register, exposes it to the Z80 and can interrupt the host.

Parameters:
- DEPTH, 8, host→MCU FIFO entries (power of 2, ≥2).
- AW, 3, log2(DEPTH).

Ports:
- I_CLK  in  1  system clock, shared with the mr16 core.
- I_RESET_N  in  1  synchronous, active-low reset.
- I_CS  in  1  host I/O chip select.
- I_RD  in  1  host read.
- I_WR  in  1  host write.
- I_A  in  1  host register select.
- I_D  in  8  host write data.
- O_D  out  8  host read data.
- O_HOST_INT  out  1  host interrupt, level.
- O_MCU_P0  out  16  to mr16 I_P0.
- I_MCU_POP  in  1  from mr16 O_I4 (read strobe, may last several cycles).
- I_MCU_TX  in  16  from mr16 O_P5.
- O_MCU_INT  out  1  to mr16 I_INT[0].
- I_MCU_ACK  in  1  from mr16 O_ACK[0].

Behaviour:
- Clock and reset: all state updates on rising I_CLK; reset when I_RESET_N=0 at the edge.
- Reset values:
  - FIFO empty; rx_valid=0; overrun=0; ien=0; irq_pend=0.
  - tx_tog_r=0, matching the mr16 O_P5 reset value of 0.
  - pop_r=0; rd_r=0.
  - O_HOST_INT=0; O_MCU_INT=0; O_MCU_P0=16'h0000.
- Host register map:
  - A=0 write: push I_D into FIFO. If the FIFO is full the byte is dropped, unless a pop occurs in the same cycle, in which case both succeed.
  - A=0 read: O_D=rx_data. The rising edge of (I_CS&I_RD&~I_A) clears rx_valid, so exactly one clear per host access.
  - A=1 read: O_D = {ien, 3'b0, overrun, rx_valid, fifo_empty, fifo_full}.
  - A=1 write: bit0=1 flushes the FIFO; bit1=1 clears overrun; bit7 → ien.
  - Host writes act on any cycle where I_CS&I_WR are high. The host bus holds WR for one I_CLK per access.
- O_D is combinational from registered state; 8'h00 when ~(I_CS&I_RD).
- O_MCU_P0 is registered, 1-cycle latency from any state change:
  - [15] = ~fifo_empty
  - [14] = rx_valid (backpressure: mr16 must not send while set)
  - [13:8] = 0
  - [7:0] = FIFO head (0 when empty).
- MCU pop: on rising edge of I_MCU_POP (pop_r tracks the previous value), pop one entry if non-empty. Pop when empty is a no-op. A held strobe never pops twice.
- MCU send: when I_MCU_TX[15] != tx_tog_r, update tx_tog_r:
  - if rx_valid=0: rx_data<=I_MCU_TX[7:0], rx_valid<=1;
  - else set overrun and drop the byte.
  - A host clear of rx_valid in the same cycle as a send accepts the new byte (rx_valid stays 1, no overrun).
- MCU interrupt:
  - irq_pend is set by any successful push; cleared by I_MCU_ACK.
  - If push and ACK occur in the same cycle, push wins (set).
  - O_MCU_INT = irq_pend.
- Host interrupt: O_HOST_INT = ien & rx_valid, registered.
- Flush precedence: flush beats a same-cycle pop and push. FIFO ends empty and irq_pend is unaffected.
- Pointers: wrap mod DEPTH. Count width is AW+1; full when count==DEPTH.
- Reset mid-transfer: all state discarded. A toggle already pending on I_MCU_TX at reset release is seen as a new byte only if I_MCU_TX[15]=1.

Decomposition:
- Shared package mr16_mbox_pkg holds:
  - register addresses (REG_DATA=0, REG_STAT=1);
  - status bit indices;
  - P0 field positions (P0_VALID=15, P0_BUSY=14);
  - TX toggle bit index (TX_TOG=15).
- One natural sub-module: mr16_mbox_fifo, a synchronous DEPTH×8 FIFO.
  - Inputs: push, pop, flush.
  - Outputs: head, full, empty, count.
  - Same-cycle push+pop is legal when full or non-empty.

Test Plan:
1. Reset, host writes 8'h41 to A=0 → O_MCU_P0=16'h8041 one cycle later; O_MCU_INT=1; pulse I_MCU_ACK → O_MCU_INT=0 next cycle, P0 unchanged.
2. Push 8'h11,8'h22,8'h33; hold I_MCU_POP high 4 cycles → exactly one pop, P0=16'h8022; two more separate pulses → P0=16'h0000, status bit1 (empty)=1.
3. Fill FIFO with 8 bytes, push 8'hFF → dropped, status=8'h01; push 8'hEE with a same-cycle POP rising edge → accepted, last entry 8'hEE.
4. Host sets ien (A=1 ← 8'h80); I_MCU_TX=16'h805A → rx_valid, O_HOST_INT=1, P0[14]=1; host reads A=0 → O_D=8'h5A, O_HOST_INT=0 after one cycle.
5. With rx_valid=1, I_MCU_TX toggles to 16'h0077 → overrun=1, rx_data unchanged; write A=1 ← 8'h02 → overrun=0.
6. FIFO holding 3 bytes, assert flush plus POP edge plus push same cycle → FIFO empty, P0=16'h0000; drop I_RESET_N for one cycle mid-operation → all outputs return to reset values.

Source files
------------

// File: rtl/mr16_mbox_pkg.sv
// mr16 host mailbox shared definitions.
// Register map, status/control bit indices, P0 layout and TX toggle bit.
package mr16_mbox_pkg;

  localparam logic REG_DATA = 1'b0;
  localparam logic REG_STAT = 1'b1;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_RXV   = 2;
  localparam int ST_OVR   = 3;
  localparam int ST_IEN   = 7;

  localparam int CT_FLUSH   = 0;
  localparam int CT_OVR_CLR = 1;
  localparam int CT_IEN     = 7;

  localparam int P0_VALID = 15;
  localparam int P0_BUSY  = 14;
  localparam int TX_TOG   = 15;

  function automatic logic [15:0] p0_word(
    input logic       valid,
    input logic       busy,
    input logic [7:0] data
  );
    logic [15:0] w;
    w           = '0;
    w[P0_VALID] = valid;
    w[P0_BUSY]  = busy;
    w[7:0]      = data;
    return w;
  endfunction

endpackage

// File: rtl/mr16_mbox_fifo.sv
// Synchronous DEPTH x 8 FIFO for host-to-MCU bytes.
// Ports: I_PUSH/I_DIN, I_POP, I_FLUSH in; O_HEAD, O_FULL, O_EMPTY, O_COUNT out.
module mr16_mbox_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          I_CLK,
  input  logic          I_RESET_N,
  input  logic          I_PUSH,
  input  logic          I_POP,
  input  logic          I_FLUSH,
  input  logic [7:0]    I_DIN,
  output logic [7:0]    O_HEAD,
  output logic          O_FULL,
  output logic          O_EMPTY,
  output logic [AW:0]   O_COUNT
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign O_EMPTY = (count == '0);
  assign O_FULL  = (count == FULL_CNT);
  assign O_COUNT = count;
  assign O_HEAD  = mem[rd_ptr];

  // A pop frees the slot, so a push into a full FIFO succeeds alongside it.
  assign do_pop  = I_POP & ~O_EMPTY & ~I_FLUSH;
  assign do_push = I_PUSH & ~I_FLUSH & (~O_FULL | do_pop);

  always_ff @(posedge I_CLK) begin
    if (!I_RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (I_FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge I_CLK) begin
    if (do_push) mem[wr_ptr] <= I_DIN;
  end

endmodule

// File: rtl/mr16_host_mailbox.sv
// Z80 host-side mailbox to the mr16 sub-CPU: byte FIFO in, toggle-flagged byte out.
// Ports: host bus I_CS/I_RD/I_WR/I_A/I_D/O_D/O_HOST_INT; mr16 side O_MCU_P0, I_MCU_POP, I_MCU_TX, O_MCU_INT, I_MCU_ACK.
module mr16_host_mailbox
  import mr16_mbox_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        I_CLK,
  input  logic        I_RESET_N,
  input  logic        I_CS,
  input  logic        I_RD,
  input  logic        I_WR,
  input  logic        I_A,
  input  logic [7:0]  I_D,
  output logic [7:0]  O_D,
  output logic        O_HOST_INT,
  output logic [15:0] O_MCU_P0,
  input  logic        I_MCU_POP,
  input  logic [15:0] I_MCU_TX,
  output logic        O_MCU_INT,
  input  logic        I_MCU_ACK
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic        host_wr;
  logic        host_push;
  logic        ctrl_wr;
  logic        flush;
  logic        ovr_clr;
  logic        rd_data;
  logic        rd_r;
  logic        rd_clr;
  logic        pop_r;
  logic        pop_edge;
  logic        pop_ok;
  logic        push_ok;
  logic        tx_tog_r;
  logic        tx_new;
  logic        rx_accept;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        overrun;
  logic        ien;
  logic        irq_pend;
  logic [7:0]  head;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic [7:0]  stat;
  logic [15:0] p0_r;
  logic        host_int_r;

  assign host_wr   = I_CS & I_WR;
  assign host_push = host_wr & (I_A == REG_DATA);
  assign ctrl_wr   = host_wr & (I_A == REG_STAT);
  assign flush     = ctrl_wr & I_D[CT_FLUSH];
  assign ovr_clr   = ctrl_wr & I_D[CT_OVR_CLR];

  // Only the first cycle of a data-register read clears rx_valid.
  assign rd_data = I_CS & I_RD & (I_A == REG_DATA);
  assign rd_clr  = rd_data & ~rd_r;

  // mr16 read strobe may be held; pop on its leading edge only.
  assign pop_edge = I_MCU_POP & ~pop_r;
  assign pop_ok   = pop_edge & ~empty & ~flush;
  assign push_ok  = host_push & ~flush & ((count != FULL_CNT) | pop_ok);

  // A byte arriving as the host drains the previous one is taken.
  assign tx_new    = I_MCU_TX[TX_TOG] ^ tx_tog_r;
  assign rx_accept = tx_new & (~rx_valid | rd_clr);

  mr16_mbox_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .I_CLK     (I_CLK),
    .I_RESET_N (I_RESET_N),
    .I_PUSH    (host_push),
    .I_POP     (pop_edge),
    .I_FLUSH   (flush),
    .I_DIN     (I_D),
    .O_HEAD    (head),
    .O_FULL    (full),
    .O_EMPTY   (empty),
    .O_COUNT   (count)
  );

  always_ff @(posedge I_CLK) begin
    if (!I_RESET_N) begin
      rd_r       <= 1'b0;
      pop_r      <= 1'b0;
      tx_tog_r   <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= 8'h00;
      overrun    <= 1'b0;
      ien        <= 1'b0;
      irq_pend   <= 1'b0;
      p0_r       <= 16'h0000;
      host_int_r <= 1'b0;
    end else begin
      rd_r     <= rd_data;
      pop_r    <= I_MCU_POP;
      tx_tog_r <= I_MCU_TX[TX_TOG];

      if (rx_accept) begin
        rx_data  <= I_MCU_TX[7:0];
        rx_valid <= 1'b1;
      end else if (rd_clr) begin
        rx_valid <= 1'b0;
      end

      if (tx_new & ~rx_accept) overrun <= 1'b1;
      else if (ovr_clr)        overrun <= 1'b0;

      if (ctrl_wr) ien <= I_D[CT_IEN];

      if (push_ok)        irq_pend <= 1'b1;
      else if (I_MCU_ACK) irq_pend <= 1'b0;

      p0_r       <= p0_word(~empty, rx_valid, empty ? 8'h00 : head);
      host_int_r <= ien & rx_valid;
    end
  end

  always_comb begin
    stat           = '0;
    stat[ST_IEN]   = ien;
    stat[ST_OVR]   = overrun;
    stat[ST_RXV]   = rx_valid;
    stat[ST_EMPTY] = empty;
    stat[ST_FULL]  = full;
  end

  always_comb begin
    O_D = 8'h00;
    if (I_CS & I_RD) O_D = (I_A == REG_STAT) ? stat : rx_data;
  end

  assign O_MCU_P0   = p0_r;
  assign O_HOST_INT = host_int_r;
  assign O_MCU_INT  = irq_pend;

endmodule
